// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared widths and state encoding for the drive envelope player
package drive_pkg;

    localparam int IQ_WIDTH_DEF   = 9;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/drive_envelope_player.sv
// rtl/drive_envelope_player.sv - plays an I/Q envelope from external memory toward the calibration unit
module drive_envelope_player
    import drive_pkg::*;
#(
    parameter int IQ_WIDTH   = IQ_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     length,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [2*IQ_WIDTH-1:0]   mem_rdata,
    output logic [IQ_WIDTH-1:0]     i_out,
    output logic [IQ_WIDTH-1:0]     q_out,
    output logic                    valid_out,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state;
    logic [ADDR_WIDTH:0]   len_sat;
    logic [ADDR_WIDTH:0]   reads_left;
    logic                  rd_pend;

    always_comb begin
        len_sat = (length > MAX_LEN) ? MAX_LEN : length;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            // Clearing rd_pend drops any read still in flight so no stale sample appears.
            state      <= IDLE;
            reads_left <= '0;
            rd_pend    <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            i_out      <= '0;
            q_out      <= '0;
            valid_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_pend <= mem_rd_en;
            if (rd_pend) begin
                valid_out <= 1'b1;
                i_out     <= mem_rdata[2*IQ_WIDTH-1:IQ_WIDTH];
                q_out     <= mem_rdata[IQ_WIDTH-1:0];
            end else begin
                valid_out <= 1'b0;
                i_out     <= '0;
                q_out     <= '0;
            end

            case (state)
                IDLE: begin
                    // The done pulse cycle is treated as part of the pulse, so start is refused there.
                    if (start && !done) begin
                        if (len_sat == '0) begin
                            state <= DONE;
                        end else begin
                            state      <= FETCH;
                            busy       <= 1'b1;
                            mem_rd_en  <= 1'b1;
                            mem_addr   <= base_addr;
                            reads_left <= len_sat - LEN_ONE;
                        end
                    end
                end
                FETCH: begin
                    if (reads_left == '0) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        mem_addr   <= mem_addr + ADDR_ONE;
                        reads_left <= reads_left - LEN_ONE;
                    end
                end
                DRAIN: begin
                    if (rd_pend && !mem_rd_en) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drive_envelope_player.sv
// tb/tb_drive_envelope_player.sv - self-checking bench for drive_envelope_player
module tb_drive_envelope_player;

    localparam int IQW = 9;
    localparam int AW  = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     length;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [2*IQW-1:0] mem_rdata;
    logic [IQW-1:0]  i_out;
    logic [IQW-1:0]  q_out;
    logic            valid_out;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [2*IQW-1:0] mem [1024];

    drive_envelope_player #(.IQ_WIDTH(IQW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .i_out(i_out), .q_out(q_out), .valid_out(valid_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Expected outputs k cycles after the start edge, straight from the pulse timing rules.
    function automatic logic [31:0] model(input int k, input int len, input int base);
        int l;
        logic rd, v, b, d;
        logic [9:0] a;
        logic [17:0] iq;
        l  = (len > 1024) ? 1024 : len;
        rd = (k < l);
        a  = rd ? 10'((base + k) % 1024) : 10'd0;
        v  = (k >= 2) && (k <= l + 1);
        iq = v ? mem[(base + k - 2) % 1024] : 18'd0;
        b  = (l > 0) && (k <= l + 1);
        d  = (k == ((l == 0) ? 1 : l + 2));
        return {rd, a, v, iq, b, d};
    endfunction

    function automatic logic [31:0] obs();
        return {mem_rd_en, mem_rd_en ? mem_addr : 10'd0, valid_out, i_out, q_out, busy, done};
    endfunction

    task automatic fill_random();
        for (int n = 0; n < 1024; n++) mem[n] = 18'($urandom);
    endtask

    task automatic issue(input int base, input int len);
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; base_addr = 10'd5; length = 11'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_addr, i_out, q_out, valid_out, busy, done} !== 31'd0)
            begin errors++; $display("FAIL reset got=%h exp=0", {mem_rd_en, mem_addr, i_out, q_out, valid_out, busy, done}); end
        rst = 1'b0; start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs() !== 32'd0) begin errors++; $display("FAIL reset_idle got=%h exp=0", obs()); end
        end
    endtask

    task automatic test_basic();
        fill_random();
        for (int n = 0; n < 4; n++) mem[n] = {9'(n + 1), 9'(-(n + 1))};
        issue(0, 4);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk); else @(negedge clk);
            checks++;
            if (obs() !== model(k, 4, 0)) begin errors++; $display("FAIL basic k=%0d got=%h exp=%h", k, obs(), model(k, 4, 0)); end
        end
    endtask

    task automatic test_wrap();
        fill_random();
        issue(1022, 4);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 4, 1022)) begin errors++; $display("FAIL wrap k=%0d got=%h exp=%h", k, obs(), model(k, 4, 1022)); end
        end
    endtask

    task automatic test_zero_length();
        issue(100, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 0, 100)) begin errors++; $display("FAIL zero_len k=%0d got=%h exp=%h", k, obs(), model(k, 0, 100)); end
        end
    endtask

    task automatic test_random();
        int base, len, l;
        fill_random();
        for (int p = 0; p < 9; p++) begin
            base = $urandom_range(0, 1023);
            len  = (p == 8) ? $urandom_range(1025, 2047) : $urandom_range(1, 40);
            l    = (len > 1024) ? 1024 : len;
            issue(base, len);
            for (int k = 0; k < l + 4; k++) begin
                @(negedge clk);
                checks++;
                if (obs() !== model(k, len, base)) begin errors++; $display("FAIL random p=%0d k=%0d got=%h exp=%h", p, k, obs(), model(k, len, base)); end
            end
        end
    endtask

    task automatic test_abort();
        int base;
        fill_random();
        base = $urandom_range(0, 1023);
        issue(base, 8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 8, base)) begin errors++; $display("FAIL abort_pre k=%0d got=%h exp=%h", k, obs(), model(k, 8, base)); end
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            checks++;
            if ({obs(), mem_addr} !== 42'd0) begin errors++; $display("FAIL abort_quiet k=%0d got=%h exp=0", k, obs()); end
        end
        base = $urandom_range(0, 1023);
        issue(base, 6);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 6, base)) begin errors++; $display("FAIL abort_restart k=%0d got=%h exp=%h", k, obs(), model(k, 6, base)); end
        end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; base_addr = 10'd7; length = 11'd5;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 32'd0) begin errors++; $display("FAIL abort_start k=%0d got=%h exp=0", k, obs()); end
        end
    endtask

    task automatic test_back_to_back();
        int base, dones;
        fill_random();
        base  = $urandom_range(0, 1023);
        dones = 0;
        issue(base, 5);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 5, base)) begin errors++; $display("FAIL restart_ignored k=%0d got=%h exp=%h", k, obs(), model(k, 5, base)); end
            if (done === 1'b1) dones++;
            start = (k + 1 <= 8);
        end
        start = 1'b0;
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_rst_mid();
        int base;
        real ph;
        fill_random();
        base = $urandom_range(0, 1023);
        issue(base, 20);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 20, base)) begin errors++; $display("FAIL rst_pre k=%0d got=%h exp=%h", k, obs(), model(k, 20, base)); end
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checks++;
            if ({obs(), mem_addr} !== 42'd0) begin errors++; $display("FAIL rst_quiet k=%0d got=%h exp=0", k, obs()); end
        end
        for (int n = 0; n < 1024; n++) begin
            ph = 6.283185307179586 * n / 1024.0;
            mem[n] = {9'($rtoi(255.0 * $sin(ph))), 9'($rtoi(255.0 * $cos(ph)))};
        end
        issue(0, 1024);
        for (int k = 0; k < 1029; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 1024, 0)) begin errors++; $display("FAIL sincos k=%0d got=%h exp=%h", k, obs(), model(k, 1024, 0)); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_length();
        test_random();
        test_abort();
        test_abort_start_idle();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
